// File: rtl/refclk_pattern_top.sv
// refclk_pattern_top: free-running binary/Gray/walking-one pattern generator on the reference clock
// Ports: ref_clk            single-ended reference clock (default build)
//        ref_clk_p/ref_clk_n differential reference clock (when DIFF_REFCLK_EN is defined)
//        rst_n              asynchronous active-low reset
//        out                registered WIDTH-bit pattern, one step every PRESCALE clocks
// Optional build macro: DIFF_REFCLK_EN
module refclk_pattern_top #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4,
  parameter int MODE     = 0
) (
`ifdef DIFF_REFCLK_EN
  input  logic             ref_clk_p,
  input  logic             ref_clk_n,
`else
  input  logic             ref_clk,
`endif
  input  logic             rst_n,
  output logic [WIDTH-1:0] out
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] WV = WIDTH'(WIDTH);
  if (WIDTH < 2) begin : g_bad_width
    $error("refclk_pattern_top: WIDTH must be >= 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("refclk_pattern_top: PRESCALE must be >= 1");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("refclk_pattern_top: MODE must be 0, 1 or 2");
  end
  logic clk;
`ifdef DIFF_REFCLK_EN
  // Differential receiver model: follow the P leg only while the pair is complementary.
  always_latch if (ref_clk_p != ref_clk_n) clk <= ref_clk_p;
`else
  assign clk = ref_clk;
`endif
  // Async assert, sync deassert: rst_int_n rises on the 2nd edge that sees rst_n high.
  logic [1:0] sync_q;
  logic       rst_int_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], 1'b1};
  assign rst_int_n = sync_q[1];
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, out_d;
  logic             tick;
  always_comb begin
    tick  = pre_q == PMAX;
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
    out_d = MODE == 0 ? cnt_q : MODE == 1 ? cnt_q ^ (cnt_q >> 1) : WIDTH'(1) << (cnt_q % WV);
  end
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) begin
      pre_q <= '0;
      cnt_q <= '0;
      out   <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      out   <= out_d;
    end
endmodule

// File: tb/tb_refclk_pattern_top.sv
// tb_refclk_pattern_top: randomized self-checking bench for refclk_pattern_top against a closed-form model
module tb_refclk_pattern_top;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] o0, o1, o2, o3;
  logic [4:0] o4;
  int n = 0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
`ifdef DIFF_REFCLK_EN
  logic ref_clk_p, ref_clk_n;
  assign ref_clk_p = clk;
  assign ref_clk_n = ~clk;
  `define TB_CLKS .ref_clk_p(ref_clk_p), .ref_clk_n(ref_clk_n)
`else
  `define TB_CLKS .ref_clk(clk)
`endif
  refclk_pattern_top #(.WIDTH(8), .PRESCALE(4), .MODE(0)) d0 (`TB_CLKS, .rst_n(rst_n), .out(o0));
  refclk_pattern_top #(.WIDTH(8), .PRESCALE(1), .MODE(0)) d1 (`TB_CLKS, .rst_n(rst_n), .out(o1));
  refclk_pattern_top #(.WIDTH(8), .PRESCALE(1), .MODE(1)) d2 (`TB_CLKS, .rst_n(rst_n), .out(o2));
  refclk_pattern_top #(.WIDTH(8), .PRESCALE(4), .MODE(2)) d3 (`TB_CLKS, .rst_n(rst_n), .out(o3));
  refclk_pattern_top #(.WIDTH(5), .PRESCALE(1), .MODE(2)) d4 (`TB_CLKS, .rst_n(rst_n), .out(o4));
  // Output after the k-th edge that sampled rst_n high: zero through E2, then the
  // encoding of the step count reached one edge earlier.
  function automatic logic [31:0] model(int w, int p, int m, int k);
    int c;
    if (k < 3) return 0;
    c = ((k - 3) / p) % (1 << w);
    return m == 0 ? c : m == 1 ? c ^ (c >> 1) : 32'(1) << (c % w);
  endfunction
  function automatic logic [36:0] model_all(int k);
    return {8'(model(8, 4, 0, k)), 8'(model(8, 1, 0, k)), 8'(model(8, 1, 1, k)),
            8'(model(8, 4, 2, k)), 5'(model(5, 1, 2, k))};
  endfunction
  task automatic tick();
    @(posedge clk);
    if (rst_n) n++;
    #1;
  endtask
  task automatic hold_reset(int cyc);
    @(negedge clk);
    rst_n = 1'b0;
    n = 0;
    repeat (cyc) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    #2 rst_n = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      total++;
      if ({o0, o1, o2, o3, o4} !== 37'd0) begin
        bad++;
        $display("FAIL reset_hold got=%h exp=0", {o0, o1, o2, o3, o4});
      end
    end
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      total++;
      if ({o0, o1, o2, o3, o4} !== 37'd0) begin
        bad++;
        $display("FAIL reset_release n=%0d got=%h exp=0", n, {o0, o1, o2, o3, o4});
      end
    end
  endtask
  task automatic test_sequence();
    int first = 0;
    repeat (60) begin
      tick();
      total++;
      if (o0 !== 8'(model(8, 4, 0, n))) begin
        bad++;
        $display("FAIL sequence n=%0d got=%h exp=%h", n, o0, 8'(model(8, 4, 0, n)));
      end
      if (first == 0 && o0 !== 8'd0) first = n;
    end
    total++;
    if (first !== 7) begin
      bad++;
      $display("FAIL first_step got=E%0d exp=E7", first);
    end
  endtask
  task automatic test_binary_wrap();
    logic [7:0] want;
    hold_reset($urandom_range(2, 12));
    repeat (270) begin
      tick();
      total++;
      if (o1 !== 8'(model(8, 1, 0, n))) begin
        bad++;
        $display("FAIL binary n=%0d got=%h exp=%h", n, o1, 8'(model(8, 1, 0, n)));
      end
      if (n >= 257 && n <= 260) begin
        want = n == 257 ? 8'hFE : n == 258 ? 8'hFF : n == 259 ? 8'h00 : 8'h01;
        total++;
        if (o1 !== want) begin
          bad++;
          $display("FAIL binary_wrap n=%0d got=%h exp=%h", n, o1, want);
        end
      end
    end
  endtask
  task automatic test_gray();
    logic [7:0] prev = 8'd0;
    hold_reset($urandom_range(2, 12));
    repeat (300) begin
      tick();
      total++;
      if (o2 !== 8'(model(8, 1, 1, n))) begin
        bad++;
        $display("FAIL gray n=%0d got=%h exp=%h", n, o2, 8'(model(8, 1, 1, n)));
      end
      if (n >= 4) begin
        total++;
        if ($countones(o2 ^ prev) !== 1) begin
          bad++;
          $display("FAIL gray_onebit n=%0d got=%h prev=%h exp=1 bit changed", n, o2, prev);
        end
      end
      if (n == 8 || n == 9) begin
        total++;
        if (o2 !== (n == 8 ? 8'h07 : 8'h05)) begin
          bad++;
          $display("FAIL gray_fixed n=%0d got=%h exp=%h", n, o2, n == 8 ? 8'h07 : 8'h05);
        end
      end
      prev = o2;
    end
  endtask
  task automatic test_walking_one();
    hold_reset($urandom_range(2, 12));
    repeat (300) begin
      tick();
      total++;
      if (o3 !== 8'(model(8, 4, 2, n)) || o4 !== 5'(model(5, 1, 2, n))) begin
        bad++;
        $display("FAIL walk n=%0d got=%h/%h exp=%h/%h", n, o3, o4, 8'(model(8, 4, 2, n)), 5'(model(5, 1, 2, n)));
      end
      if (n >= 3) begin
        total++;
        if ($countones(o3) !== 1 || $countones(o4) !== 1) begin
          bad++;
          $display("FAIL walk_onehot n=%0d got=%h/%h exp=one bit set", n, o3, o4);
        end
      end
      if (n == 3 || n == 39) begin
        total++;
        if (o3 !== (n == 3 ? 8'h01 : 8'h02)) begin
          bad++;
          $display("FAIL walk_fixed n=%0d got=%h exp=%h", n, o3, n == 3 ? 8'h01 : 8'h02);
        end
      end
    end
  endtask
  task automatic test_midrun_reset();
    for (int t = 0; t < 4; t++) begin
      int k = t == 0 ? 37 : int'($urandom_range(5, 80));
      hold_reset($urandom_range(2, 12));
      repeat (k) begin
        tick();
        total++;
        if (o0 !== 8'(model(8, 4, 0, n))) begin
          bad++;
          $display("FAIL midrun_pre n=%0d got=%h exp=%h", n, o0, 8'(model(8, 4, 0, n)));
        end
      end
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      total++;
      if ({o0, o1, o2, o3, o4} !== 37'd0) begin
        bad++;
        $display("FAIL midrun_async k=%0d got=%h exp=0", k, {o0, o1, o2, o3, o4});
      end
      hold_reset($urandom_range(2, 6));
      repeat (30) begin
        tick();
        total++;
        if (o0 !== 8'(model(8, 4, 0, n)) || o3 !== 8'(model(8, 4, 2, n))) begin
          bad++;
          $display("FAIL midrun_restart n=%0d got=%h/%h exp=%h/%h", n, o0, o3, 8'(model(8, 4, 0, n)), 8'(model(8, 4, 2, n)));
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      hold_reset($urandom_range(1, 3));
      repeat ($urandom_range(3, 20)) begin
        tick();
        total++;
        if ({o0, o1, o2, o3, o4} !== model_all(n)) begin
          bad++;
          $display("FAIL back_to_back n=%0d got=%h exp=%h", n, {o0, o1, o2, o3, o4}, model_all(n));
        end
      end
    end
  endtask
  task automatic test_long_run();
    hold_reset(10);
    repeat (1000) begin
      tick();
      total++;
      if ({o0, o1, o2, o3, o4} !== model_all(n)) begin
        bad++;
        $display("FAIL long_run n=%0d got=%h exp=%h", n, {o0, o1, o2, o3, o4}, model_all(n));
      end
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1, "watchdog expired");
  end
  initial begin
    test_reset();
    test_sequence();
    test_binary_wrap();
    test_gray();
    test_walking_one();
    test_midrun_reset();
    test_back_to_back();
    test_long_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/refclk_pattern_top.md
Name: refclk_pattern_top

Overview:
- Top-level, free-running pattern generator clocked from the board reference clock.
- After reset release it drives a WIDTH-bit output that advances once every PRESCALE clocks.
- Three fixed encodings are selectable: binary count, Gray code, walking one.
- It has no data inputs; it serves as the project's default top and smoke-test target.

Parameters:
- WIDTH, 8, output width in bits. Must be >= 2.
- PRESCALE, 4, number of clocks per output step. Must be >= 1.
- MODE, 0, output encoding: 0 = binary, 1 = Gray, 2 = walking one.
- Illegal values of any parameter cause an elaboration-time error.

Ports:
- ref_clk, input, 1, reference clock; single clock domain, 100 MHz nominal. Replaced by ref_clk_p/ref_clk_n when DIFF_REFCLK_EN is defined.
- rst_n, input, 1, asynchronous active-low reset.
- out, output, WIDTH, registered pattern output.

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port is ref_clk (ref_clk_p/ref_clk_n under DIFF_REFCLK_EN); reset port is rst_n.
- Reset synchronizer:
  - Two-flop chain with asynchronous assert and synchronous deassert; it produces rst_int_n.
  - rst_n low forces rst_int_n low immediately, with no clock needed.
  - rst_int_n rises on the 2nd rising edge that samples rst_n high (E1, E2).
- While rst_int_n is low:
  - out = 0.
  - Prescaler pre_cnt = 0.
  - Step counter cnt = 0.
  - These values apply asynchronously, including on reset mid-operation.
- Prescaler:
  - Starting at E3, pre_cnt increments each edge.
  - tick = (pre_cnt == PRESCALE-1), combinational.
  - On tick, pre_cnt wraps to 0.
  - PRESCALE=1 gives tick every cycle.
- Step counter:
  - cnt is WIDTH bits and increments by 1 on each edge where tick = 1.
  - It wraps from 2^WIDTH-1 to 0 with no flag.
- Output register:
  - Every edge with rst_int_n high, out <= f(cnt), where f is:
    - MODE 0: f = cnt.
    - MODE 1: f = cnt ^ (cnt >> 1).
    - MODE 2: f = 1 << (cnt mod WIDTH). cnt still counts 0..2^WIDTH-1; for non-power-of-2 WIDTH the rotation restarts at bit 0 when cnt wraps.
  - Latency is 1 clock from cnt to out. out is the only output and is always registered (glitch-free).
- First output values after reset:
  - First nonzero binary value: cnt = 1 after the edge at E3+PRESCALE-1; out = 1 one edge later.
  - In MODE 2, out becomes 0x01 at the first edge after E2, because f(0) = 1.
- Reset asserted in the same cycle as a tick: reset wins.
- No other inputs exist, so no other simultaneous events are possible.

Optional Feature:
- Macro: DIFF_REFCLK_EN.
- Defined:
  - ref_clk is removed; ref_clk_p and ref_clk_n (input, 1 each) are added.
  - Internal clock comes from a differential input buffer (IBUFDS in synthesis).
  - Behavioural model: clk follows ref_clk_p when ref_clk_p != ref_clk_n, and holds otherwise.
- Undefined: single-ended ref_clk through a global clock buffer (BUFG in synthesis; wire in simulation).
- All other behaviour is identical in both builds.

Test Plan:
1. Reset release, defaults (WIDTH=8, PRESCALE=4, MODE=0), ref_clk half period 5 ns:
   - rst_n low for 10 cycles, then high -> out = 0x00 through E2.
   - out = 0x01 at the edge after E6, then increments by 1 every 4 clocks.
2. Binary wrap (PRESCALE=1, MODE=0):
   - Run 260 clocks past release -> out counts 0xFE, 0xFF, 0x00, 0x01 on consecutive edges.
   - No stall at the wrap.
3. Gray encoding (MODE=1, PRESCALE=1):
   - cnt 5 -> out 0x07; cnt 6 -> out 0x05.
   - Every step changes exactly one bit over 300 clocks.
4. Walking one (MODE=2, WIDTH=8):
   - First post-reset out is 0x01.
   - cnt = 9 -> out = 0x02.
   - Exactly one bit is set at all times after E3.
5. Mid-run reset:
   - Assert rst_n low between clock edges after 37 clocks -> out = 0x00 before the next edge.
   - Deassert -> sequence restarts exactly as in scenario 1.
6. DIFF_REFCLK_EN build:
   - Drive complementary ref_clk_p/ref_clk_n at 100 MHz for 10 us -> out sequence is identical to scenario 1, cycle for cycle.
